// File: rtl/codec_init_sequencer.sv
// -----------------------------------------------------------------------------
// codec_init_sequencer
//
// Pushes a table of 16-bit register words to an external audio codec through
// an I2C write controller. Each run does three things:
//   - waits a power-up delay;
//   - sends every table entry as one write transaction
//     (address, high byte, low byte, stop);
//   - leaves idle gaps between the transactions.
// A run starts after reset when start is seen, or again from DONE/ERROR.
// The table sits outside this block as a combinational lookup addressed by
// entry_index.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   start            level request, sampled in IDLE/DONE/ERROR
//   entry_word       table word for entry_index ([15:8] sent first)
//   entry_index      current table index
//   i2c_enable       controller enable
//   i2c_mode         controller mode, constant WRITE
//   i2c_addr         controller peripheral address, constant PERIPH_ADDR
//   i2c_byte         controller input byte
//   i2c_ready        controller ready
//   i2c_wip          controller write-in-progress
//   busy             run in progress
//   done             high while in DONE
//   error            sticky wip timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module codec_init_sequencer #(
  parameter int         NUM_ENTRIES    = 10,
  parameter int         IDX_W          = 4,
  parameter logic [6:0] PERIPH_ADDR    = 7'h1A,
  parameter int         POWERUP_CYCLES = 1000,
  parameter int         GAP_CYCLES     = 16,
  parameter int         WIP_TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      entry_word,
  output logic [IDX_W-1:0] entry_index,
  output logic             i2c_enable,
  output logic             i2c_mode,
  output logic [6:0]       i2c_addr,
  output logic [7:0]       i2c_byte,
  input  logic             i2c_ready,
  input  logic             i2c_wip,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // One counter serves both the power-up delay and the inter-transaction gap.
  localparam int CNT_MAX = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(WIP_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WIP_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DELAY     = 4'd1,
    S_LOAD      = 4'd2,
    S_SEND_HI   = 4'd3,
    S_SEND_LO   = 4'd4,
    S_STOP_WAIT = 4'd5,
    S_GAP       = 4'd6,
    S_DONE      = 4'd7,
    S_ABORT     = 4'd8,
    S_ERROR     = 4'd9
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [TMO_W-1:0] r_tmo, w_tmo;
  logic             r_wip_d;
  logic             r_seen_rise, w_seen_rise;
  logic [7:0]       r_lo_byte, w_lo_byte;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic             r_enable, w_enable;
  logic [7:0]       r_byte, w_byte;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_error, w_error;
  logic             w_rise, w_fall;

  assign w_rise = i2c_wip & ~r_wip_d;
  assign w_fall = ~i2c_wip & r_wip_d;

  assign entry_index = r_idx;
  assign i2c_enable  = r_enable;
  assign i2c_mode    = 1'b1;
  assign i2c_addr    = PERIPH_ADDR;
  assign i2c_byte    = r_byte;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_tmo       = r_tmo;
    w_seen_rise = r_seen_rise;
    w_lo_byte   = r_lo_byte;
    w_idx       = r_idx;
    w_enable    = r_enable;
    w_byte      = r_byte;
    w_busy      = r_busy;
    w_done      = r_done;
    w_error     = r_error;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state = S_DELAY;
          w_cnt   = CNT_W'(0);
          w_idx   = IDX_W'(0);
          w_done  = 1'b0;
          w_error = 1'b0;
          w_busy  = 1'b1;
        end else begin
          w_state = r_state;
        end
      end

      S_DELAY: begin
        if (r_cnt == PWR_LAST) begin
          w_state = S_LOAD;
          w_cnt   = CNT_W'(0);
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      // Waits here without a timeout until the controller is ready.
      S_LOAD: begin
        if (i2c_ready) begin
          w_lo_byte   = entry_word[7:0];
          w_byte      = entry_word[15:8];
          w_enable    = 1'b1;
          w_tmo       = TMO_W'(0);
          w_seen_rise = 1'b0;
          w_state     = S_SEND_HI;
        end else begin
          w_state = S_LOAD;
        end
      end

      // Each byte finishes on a wip fall that follows a wip rise. The next
      // byte is set up on that fall, ahead of the controller's ACK phase,
      // which is when it latches input_byte again.
      S_SEND_HI, S_SEND_LO: begin
        if (w_rise) begin
          w_tmo       = TMO_W'(0);
          w_seen_rise = 1'b1;
        end else if (w_fall) begin
          w_tmo = TMO_W'(0);
          if (r_seen_rise && (r_state == S_SEND_HI)) begin
            w_byte      = r_lo_byte;
            w_seen_rise = 1'b0;
            w_state     = S_SEND_LO;
          end else if (r_seen_rise) begin
            w_enable    = 1'b0;
            w_seen_rise = 1'b0;
            w_state     = S_STOP_WAIT;
          end else begin
            w_state = r_state;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_enable = 1'b0;
          w_error  = 1'b1;
          w_state  = S_ABORT;
        end else begin
          w_tmo = r_tmo + TMO_W'(1);
        end
      end

      S_STOP_WAIT: begin
        if (i2c_ready) begin
          w_state = S_GAP;
          w_cnt   = CNT_W'(0);
        end else begin
          w_state = S_STOP_WAIT;
        end
      end

      // The index advances on leaving GAP, so it is stable for at least the
      // whole LOAD cycle before entry_word is sampled.
      S_GAP: begin
        if (r_cnt != GAP_LAST) begin
          w_cnt = r_cnt + CNT_W'(1);
        end else if (r_idx == IDX_LAST) begin
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_idx   = r_idx + IDX_W'(1);
          w_cnt   = CNT_W'(0);
          w_state = S_LOAD;
        end
      end

      // entry_index is left unchanged so the failing entry stays visible.
      S_ABORT: begin
        if (i2c_ready) begin
          w_state = S_ERROR;
          w_busy  = 1'b0;
        end else begin
          w_state = S_ABORT;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers, plus the wip delay used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_W'(0);
      r_tmo       <= TMO_W'(0);
      r_wip_d     <= 1'b0;
      r_seen_rise <= 1'b0;
      r_lo_byte   <= 8'h00;
      r_idx       <= IDX_W'(0);
      r_enable    <= 1'b0;
      r_byte      <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_tmo       <= w_tmo;
      r_wip_d     <= i2c_wip;
      r_seen_rise <= w_seen_rise;
      r_lo_byte   <= w_lo_byte;
      r_idx       <= w_idx;
      r_enable    <= w_enable;
      r_byte      <= w_byte;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_error     <= w_error;
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_codec_init_sequencer
//
// Checks the sequencer with NUM_ENTRIES=3, POWERUP_CYCLES=5, GAP_CYCLES=4 and
// WIP_TIMEOUT=32. A behavioural I2C controller model latches each byte the
// sequencer presents. A monitor compares every latched byte with the queue of
// expected table bytes, which the stimulus pushes when it starts a run.
// -----------------------------------------------------------------------------
module tb_codec_init_sequencer;

  localparam int M_IDLE  = 0;
  localparam int M_ADDR  = 1;
  localparam int M_LATCH = 2;
  localparam int M_DATA  = 3;
  localparam int M_ACK   = 4;
  localparam int M_STOP  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] entry_word;
  logic [3:0]  entry_index;
  logic        i2c_enable;
  logic        i2c_mode;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_byte;
  logic        i2c_ready;
  logic        i2c_wip;
  logic        busy;
  logic        done;
  logic        error;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_byte;
  event        byte_ev;
  logic        wip_en  = 1'b1;
  logic        mon_en  = 1'b1;
  logic        hold_rdy = 1'b0;

  always #5 clk = ~clk;

  codec_init_sequencer #(
    .NUM_ENTRIES(3), .IDX_W(4), .PERIPH_ADDR(7'h1A),
    .POWERUP_CYCLES(5), .GAP_CYCLES(4), .WIP_TIMEOUT(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .entry_word(entry_word),
    .entry_index(entry_index), .i2c_enable(i2c_enable), .i2c_mode(i2c_mode),
    .i2c_addr(i2c_addr), .i2c_byte(i2c_byte), .i2c_ready(i2c_ready),
    .i2c_wip(i2c_wip), .busy(busy), .done(done), .error(error)
  );

  // Combinational table lookup.
  always_comb begin
    case (entry_index)
      4'd0:    entry_word = 16'h1E00;
      4'd1:    entry_word = 16'h0C10;
      4'd2:    entry_word = 16'h1201;
      default: entry_word = 16'h0000;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The main thread samples and drives 3 time units after each rising edge.
  // The controller model drives 1 time unit after the edge, so it always
  // updates first.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push_table();
    exp_q.push_back(8'h1E); exp_q.push_back(8'h00);
    exp_q.push_back(8'h0C); exp_q.push_back(8'h10);
    exp_q.push_back(8'h12); exp_q.push_back(8'h01);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic end_of_run(input string name);
    chk({name, "_busy"},  {31'd0, busy},  32'd0);
    chk({name, "_error"}, {31'd0, error}, 32'd0);
    chk({name, "_index"}, {28'd0, entry_index}, 32'd2);
    chk({name, "_bytes_left"}, exp_q.size(), 32'd0);
  endtask

  // Behavioural I2C write controller.
  // Address phase: 3 cycles. Each byte: latch input_byte, wip high for
  // 4 cycles, then a 2-cycle ACK phase. If enable is still high after the ACK
  // phase it latches the next byte, otherwise it issues a stop.
  initial begin
    int m_st;
    int m_cnt;
    m_st = M_IDLE;
    m_cnt = 0;
    i2c_ready = 1'b1;
    i2c_wip = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m_st = M_IDLE; m_cnt = 0; i2c_ready = 1'b1; i2c_wip = 1'b0;
      end else begin
        case (m_st)
          M_IDLE: begin
            i2c_ready = !hold_rdy;
            if (i2c_enable && !hold_rdy) begin
              i2c_ready = 1'b0; m_cnt = 0; m_st = M_ADDR;
            end
          end
          M_ADDR:  if (m_cnt == 2) m_st = M_LATCH; else m_cnt++;
          M_LATCH: begin
            m_cnt = 0;
            if (!i2c_enable) m_st = M_STOP;
            else begin
              obs_byte = i2c_byte;
              if (mon_en) -> byte_ev;
              i2c_wip = wip_en;
              m_st = M_DATA;
            end
          end
          M_DATA: if (m_cnt == 3) begin i2c_wip = 1'b0; m_cnt = 0; m_st = M_ACK; end else m_cnt++;
          M_ACK:  if (m_cnt == 1) m_st = M_LATCH; else m_cnt++;
          M_STOP: if (m_cnt == 1) begin i2c_ready = 1'b1; m_st = M_IDLE; end else m_cnt++;
          default: m_st = M_IDLE;
        endcase
      end
    end
  end

  // Scoreboard monitor: every byte the controller latches is compared with
  // the oldest expected byte.
  initial begin
    forever begin
      @(byte_ev);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h expected none", obs_byte);
      end else begin
        chk("byte_order", {24'd0, obs_byte}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int n;
    logic bad;
    reset = 1'b1;
    start = 1'b0;
    tick(); tick();
    chk("rst_enable", {31'd0, i2c_enable}, 32'd0);
    chk("rst_byte",   {24'd0, i2c_byte},   32'd0);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_done",   {31'd0, done},       32'd0);
    chk("rst_error",  {31'd0, error},      32'd0);
    chk("rst_index",  {28'd0, entry_index}, 32'd0);
    chk("mode",       {31'd0, i2c_mode},   32'd1);
    chk("addr",       {25'd0, i2c_addr},   32'h1A);
    reset = 1'b0;
    tick();

    // Run 1: power-up latency and inter-transaction gap.
    push_table();
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 1;
    while (!i2c_enable && n < 100) begin tick(); n++; end
    chk("powerup_latency", n, 32'd7);
    for (int t = 1; t < 3; t++) begin
      n = 0;
      while (i2c_enable && n < 200) begin tick(); n++; end
      n = 0;
      for (int k = 0; k < 200 && !i2c_enable; k++) begin
        if (i2c_ready) n++;
        tick();
      end
      chk("gap_ready_cycles", n, 32'd6);
    end
    wait_done("run1_done");
    end_of_run("run1");

    // Run 2: restart from DONE, with start pulses during SEND_LO and GAP.
    push_table();
    pulse_start();
    n = 0;
    while (!(i2c_enable && i2c_byte == 8'h00) && n < 200) begin tick(); n++; end
    pulse_start();
    n = 0;
    while (i2c_enable && n < 200) begin tick(); n++; end
    n = 0;
    while (!i2c_ready && n < 200) begin tick(); n++; end
    tick();
    pulse_start();
    wait_done("run2_done");
    end_of_run("run2");

    // Run 3: controller not ready in LOAD for more than 50 cycles.
    hold_rdy = 1'b1;
    push_table();
    pulse_start();
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (i2c_enable) bad = 1'b1;
      tick();
    end
    chk("hold_no_enable", {31'd0, bad},   32'd0);
    chk("hold_no_error",  {31'd0, error}, 32'd0);
    chk("hold_busy",      {31'd0, busy},  32'd1);
    hold_rdy = 1'b0;
    wait_done("run3_done");
    end_of_run("run3");

    // Run 4: wip never asserted, so the transaction times out.
    wip_en = 1'b0;
    mon_en = 1'b0;
    pulse_start();
    n = 0;
    while (!i2c_enable && n < 100) begin tick(); n++; end
    n = 0;
    while (!error && n < 100) begin tick(); n++; end
    chk("timeout_cycles", n, 32'd32);
    chk("timeout_enable", {31'd0, i2c_enable}, 32'd0);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_error", {31'd0, error}, 32'd1);
    chk("abort_done",  {31'd0, done},  32'd0);
    chk("abort_index", {28'd0, entry_index}, 32'd0);
    wip_en = 1'b1;
    mon_en = 1'b1;
    push_table();
    pulse_start();
    chk("error_cleared", {31'd0, error}, 32'd0);
    wait_done("run5_done");
    end_of_run("run5");

    // Run 6: reset during the low byte of the first transaction.
    push_table();
    pulse_start();
    n = 0;
    while (!(i2c_enable && i2c_byte == 8'h00) && n < 200) begin tick(); n++; end
    chk("reached_send_lo", {31'd0, i2c_enable}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_enable", {31'd0, i2c_enable}, 32'd0);
    chk("midrst_busy",   {31'd0, busy},       32'd0);
    chk("midrst_index",  {28'd0, entry_index}, 32'd0);
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (i2c_enable || busy) bad = 1'b1;
      tick();
    end
    chk("post_rst_quiet", {31'd0, bad}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
